// File: rtl/mask_sched_pkg.sv
// Shared widths and FSM state encoding for the mask range scheduler.
// Optional checksum feature: MASK_SCHED_SUM_EN.
package mask_sched_pkg;

   localparam int MASK_W = 64;
   localparam int SEL_W  = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/mask_range_gen.sv
// Combinational inclusive bit-range mask: bit i set iff lo <= i <= hi.
// An inverted range (lo > hi) naturally yields an all-zero mask.
module mask_range_gen
   import mask_sched_pkg::*;
(
   input  logic [SEL_W-1:0]  lo_i,
   input  logic [SEL_W-1:0]  hi_i,
   output logic [MASK_W-1:0] mask_o
);

   for (genvar i = 0; i < MASK_W; i++) begin : g_bit
      localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
      assign mask_o[i] = (lo_i <= IDX) && (IDX <= hi_i);
   end

endmodule

// File: rtl/mask_range_sched.sv
// Two-requester round-robin scheduler emitting sliding range-mask bursts.
// Checksum output enabled by defining MASK_SCHED_SUM_EN.
module mask_range_sched
   import mask_sched_pkg::*;
#(
   parameter int BEAT_W = 4
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [SEL_W-1:0]  a_lo,
   input  logic [SEL_W-1:0]  a_hi,
   input  logic [BEAT_W-1:0] a_count,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [SEL_W-1:0]  b_lo,
   input  logic [SEL_W-1:0]  b_hi,
   input  logic [BEAT_W-1:0] b_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MASK_W-1:0] out_mask,
   output logic              out_last,
   output logic              out_src
`ifdef MASK_SCHED_SUM_EN
   ,
   output logic [MASK_W-1:0] sum
`endif
);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  lo_q, lo_d, hi_q, hi_d;
   logic [BEAT_W-1:0] cnt_q, cnt_d;
   logic              src_q, src_d;
   logic              lastb_q, lastb_d;
   logic [MASK_W-1:0] mask;
   logic              gnt_a, gnt_b, hs, acc, fin;

   mask_range_gen u_gen (
      .lo_i   (lo_q),
      .hi_i   (hi_q),
      .mask_o (mask)
   );

   // lastb_q=1 means B was granted last, so contention goes to A
   assign gnt_b = b_valid && (!a_valid || !lastb_q);
   assign gnt_a = a_valid && !gnt_b;
   assign hs    = (a_valid && a_ready) || (b_valid && b_ready);
   assign acc   = out_valid && out_ready;
   assign fin   = (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (!reset_l) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (hs)         state_d = ST_RUN;
         ST_RUN:  if (acc && fin) state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      a_ready   = 1'b0;
      b_ready   = 1'b0;
      out_valid = 1'b0;
      out_mask  = '0;
      out_last  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            a_ready = reset_l && gnt_a;
            b_ready = reset_l && gnt_b;
         end
         ST_RUN: begin
            out_valid = 1'b1;
            out_mask  = mask;
            out_last  = fin;
         end
         default: ;
      endcase
   end

   assign out_src = src_q;

   always_comb begin
      lo_d    = lo_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      lastb_d = lastb_q;
      if (hs) begin
         lo_d    = gnt_b ? b_lo : a_lo;
         hi_d    = gnt_b ? b_hi : a_hi;
         cnt_d   = gnt_b ? b_count : a_count;
         src_d   = gnt_b;
         lastb_d = gnt_b;
      end else if (acc && !fin) begin
         lo_d  = lo_q + SEL_W'(1);
         hi_d  = hi_q + SEL_W'(1);
         cnt_d = cnt_q - BEAT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_l) begin
         lo_q    <= '0;
         hi_q    <= '0;
         cnt_q   <= '0;
         src_q   <= 1'b0;
         lastb_q <= 1'b1;
      end else begin
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         lastb_q <= lastb_d;
      end
   end

`ifdef MASK_SCHED_SUM_EN
   logic [MASK_W-1:0] sum_q;

   always_ff @(posedge clk) begin
      if (!reset_l)  sum_q <= '0;
      else if (acc)  sum_q <= {sum_q[MASK_W-2:0], sum_q[MASK_W-1]} ^ out_mask;
   end

   assign sum = sum_q;
`endif

endmodule

// File: tb/tb_mask_range_sched.sv
// Directed self-checking bench for mask_range_sched.
// Checksum checks are compiled in when MASK_SCHED_SUM_EN is defined.
module tb_mask_range_sched;

   logic        clk = 1'b0;
   logic        reset_l;
   logic        a_valid, b_valid, a_ready, b_ready;
   logic [5:0]  a_lo, a_hi, b_lo, b_hi;
   logic [3:0]  a_count, b_count;
   logic        out_valid, out_ready, out_last, out_src;
   logic [63:0] out_mask;
`ifdef MASK_SCHED_SUM_EN
   logic [63:0] sum;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mask_range_sched #(.BEAT_W(4)) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_lo      (a_lo),
      .a_hi      (a_hi),
      .a_count   (a_count),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_lo      (b_lo),
      .b_hi      (b_hi),
      .b_count   (b_count),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_mask  (out_mask),
      .out_last  (out_last),
      .out_src   (out_src)
`ifdef MASK_SCHED_SUM_EN
      ,
      .sum       (sum)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_a(input logic v, input logic [5:0] lo,
                        input logic [5:0] hi, input logic [3:0] c);
      a_valid = v; a_lo = lo; a_hi = hi; a_count = c;
      #1;
   endtask

   task automatic set_b(input logic v, input logic [5:0] lo,
                        input logic [5:0] hi, input logic [3:0] c);
      b_valid = v; b_lo = lo; b_hi = hi; b_count = c;
      #1;
   endtask

   task automatic beat(input string tag, input logic [63:0] m,
                       input logic last, input logic src);
      chk({tag, "_v"}, 64'(out_valid), 64'd1);
      chk({tag, "_m"}, out_mask, m);
      chk({tag, "_l"}, 64'(out_last), 64'(last));
      chk({tag, "_s"}, 64'(out_src), 64'(src));
   endtask

   task automatic do_reset();
      reset_l = 1'b0;
      step();
      step();
      reset_l = 1'b1;
      #1;
   endtask

   initial begin
      reset_l = 1'b0; out_ready = 1'b1;
      a_valid = 0; a_lo = 0; a_hi = 0; a_count = 0;
      b_valid = 0; b_lo = 0; b_hi = 0; b_count = 0;
      step();
      step();
      chk("rst_ov", 64'(out_valid), 64'd0);
      chk("rst_ar", 64'(a_ready), 64'd0);
      chk("rst_br", 64'(b_ready), 64'd0);
      chk("rst_m", out_mask, 64'd0);
      chk("rst_l", 64'(out_last), 64'd0);
      chk("rst_s", 64'(out_src), 64'd0);
`ifdef MASK_SCHED_SUM_EN
      chk("rst_sum", sum, 64'd0);
`endif
      reset_l = 1'b1;
      step();

      // single beat from A
      set_a(1, 6'd3, 6'd5, 4'd0);
      chk("t1_ar", 64'(a_ready), 64'd1);
      chk("t1_br", 64'(b_ready), 64'd0);
      chk("t1_ov0", 64'(out_valid), 64'd0);
      step();
      set_a(0, 0, 0, 0);
      beat("t1", 64'h0000_0000_0000_0038, 1, 0);
      step();
      chk("t1_end", 64'(out_valid), 64'd0);

      // wraparound 63 -> 0
      set_a(1, 6'd63, 6'd63, 4'd1);
      step();
      set_a(0, 0, 0, 0);
      beat("t2a", 64'h8000_0000_0000_0000, 0, 0);
      step();
      beat("t2b", 64'h0000_0000_0000_0001, 1, 0);
      step();
      chk("t2_end", 64'(out_valid), 64'd0);

      // inverted and full ranges
      set_b(1, 6'd10, 6'd2, 4'd0);
      chk("t3_br", 64'(b_ready), 64'd1);
      step();
      set_b(0, 0, 0, 0);
      beat("t3a", 64'h0, 1, 1);
      step();
      set_a(1, 6'd0, 6'd63, 4'd0);
      step();
      set_a(0, 0, 0, 0);
      beat("t3b", 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
      step();

      // contention alternates A, B, A from fresh reset, with stall
      do_reset();
      set_b(1, 6'd8, 6'd8, 4'd0);
      set_a(1, 6'd0, 6'd0, 4'd1);
      chk("t4_ar0", 64'(a_ready), 64'd1);
      chk("t4_br0", 64'(b_ready), 64'd0);
      step();
      out_ready = 1'b0;
      #1;
      beat("t4a0", 64'h1, 0, 0);
      chk("t4_run_ar", 64'(a_ready), 64'd0);
      chk("t4_run_br", 64'(b_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_hold_m", out_mask, 64'h1);
         chk("t4_hold_l", 64'(out_last), 64'd0);
      end
      out_ready = 1'b1;
      step();
      beat("t4a1", 64'h2, 1, 0);
      step();
      chk("t4_gap_ov", 64'(out_valid), 64'd0);
      chk("t4_gap_br", 64'(b_ready), 64'd1);
      chk("t4_gap_ar", 64'(a_ready), 64'd0);
      step();
      beat("t4b", 64'h100, 1, 1);
      step();
      chk("t4_gap2_ar", 64'(a_ready), 64'd1);
      chk("t4_gap2_br", 64'(b_ready), 64'd0);
      step();
      beat("t4a2", 64'h1, 0, 0);
      set_a(0, 0, 0, 0);
      step();
      beat("t4a3", 64'h2, 1, 0);
      step();
      chk("t4_gap3_br", 64'(b_ready), 64'd1);
      set_b(0, 0, 0, 0);
      step();
      chk("t4_idle", 64'(out_valid), 64'd0);

      // reset mid-burst at beat 2 of 8
      set_a(1, 6'd0, 6'd0, 4'd7);
      step();
      set_a(0, 0, 0, 0);
      beat("t5b0", 64'h1, 0, 0);
      step();
      beat("t5b1", 64'h2, 0, 0);
      reset_l = 1'b0;
      step();
      chk("t5_rst_ov", 64'(out_valid), 64'd0);
`ifdef MASK_SCHED_SUM_EN
      chk("t5_rst_sum", sum, 64'd0);
`endif
      reset_l = 1'b1;
      step();
      chk("t5_post_ov", 64'(out_valid), 64'd0);
      set_a(1, 6'd3, 6'd5, 4'd0);
      step();
      set_a(0, 0, 0, 0);
      beat("t5c", 64'h38, 1, 0);
      step();
      set_a(1, 6'd0, 6'd0, 4'd0);
      step();
      set_a(0, 0, 0, 0);
      beat("t5d", 64'h1, 1, 0);
      step();
      chk("t5_end", 64'(out_valid), 64'd0);
`ifdef MASK_SCHED_SUM_EN
      chk("t5_sum", sum, 64'h0000_0000_0000_0071);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mask_range_sched.md
MASK_RANGE_SCHED -- requirements
Module: mask_range_sched

Interface
REQ-001 SHALL have parameter BEAT_W, default 4: width of the beat-count field; a burst is count+1 beats (1..16 at default).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_l, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have ports a_valid/b_valid, input, 1 each: request A/B pending.
REQ-005 SHALL have ports a_ready/b_ready, output, 1 each: request A/B accepted this cycle.
REQ-006 SHALL have ports a_lo/a_hi and b_lo/b_hi, input, 6 each: inclusive bit range of the first beat.
REQ-007 SHALL have ports a_count/b_count, input, BEAT_W each: beats minus one.
REQ-008 SHALL have port out_valid, output, 1: out_mask holds a valid beat.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts the beat.
REQ-010 SHALL have port out_mask, output, 64: generated mask.
REQ-011 SHALL have port out_last, output, 1: the current beat is the final beat of its burst.
REQ-012 SHALL have port out_src, output, 1: 0 = burst from A, 1 = burst from B.
REQ-013 SHALL have port sum, output, 64: running checksum; present only when MASK_SCHED_SUM_EN is defined.

Function
REQ-014 SHALL set mask bit i (0..63) iff lo <= i and i <= hi, both as unsigned 6-bit compares; lo > hi SHALL give an all-zero mask.
REQ-015 SHALL implement FSM states IDLE and RUN.
REQ-016 SHALL assert a_ready/b_ready only in IDLE, and only for the granted requester; a handshake occurs on valid & ready.
REQ-017 SHALL grant the sole valid requester; when both are valid, SHALL grant the requester not granted last; the first contention after reset SHALL go to A.
REQ-018 SHALL move IDLE -> RUN on a handshake, latch lo, hi, count and src, and present the first beat with out_valid=1 in the next cycle.
REQ-019 SHALL hold out_mask, out_last and out_src stable while out_valid & !out_ready.
REQ-020 SHALL, on each beat accepted (out_valid & out_ready) that is not last, increment lo and hi by 1 modulo 64 (63 -> 0), decrement the remaining count, and present the next beat in the next cycle.
REQ-021 SHALL assert out_last when the remaining count is 0.
REQ-022 SHALL return RUN -> IDLE when the last beat is accepted, deassert out_valid in the next cycle, and leave one idle cycle before the next grant.
REQ-023 SHALL ignore request inputs while in RUN.
REQ-024 SHALL update sum on every accepted beat as sum <= {sum[62:0], sum[63]} ^ out_mask.

Reset
REQ-025 SHALL, while reset_l=0, force state IDLE, out_valid=0, a_ready=b_ready=0, out_mask=0, out_last=0, out_src=0, sum=0 and the grant pointer to favour A.
REQ-026 SHALL abandon any burst in progress when reset is asserted mid-burst, with no further beat output.

Configuration
REQ-027 SHALL, with MASK_SCHED_SUM_EN defined, implement the sum port and its register as in REQ-024.
REQ-028 SHALL, without MASK_SCHED_SUM_EN, omit the sum port and its register, with all other behaviour unchanged.

Structure
REQ-029 SHALL place MASK_W=64, SEL_W=6 and the FSM state enum in package mask_sched_pkg.
REQ-030 SHALL compute the mask in a combinational sub-module mask_range_gen (inputs lo, hi; output a 64-bit mask), using one per-bit compare per bit.

Verification
REQ-031 SHALL test A only, lo=3, hi=5, count=0 -> one beat with mask 0x0000000000000038, out_last=1, out_src=0, and out_valid rising one cycle after the handshake.
REQ-032 SHALL test lo=63, hi=63, count=1 -> beats 0x8000000000000000, then 0x0000000000000001 with out_last=1.
REQ-033 SHALL test lo=10, hi=2 -> mask 0x0, and lo=0, hi=63 -> 0xFFFFFFFFFFFFFFFF.
REQ-034 SHALL test A and B held valid continuously -> grants alternate A, B, A, B, with one idle cycle between bursts; with out_ready=0 for 3 cycles, out_mask SHALL hold unchanged.
REQ-035 SHALL test, with MASK_SCHED_SUM_EN defined, beats 0x38 then 0x1 after reset -> sum=0x0000000000000071.
REQ-036 SHALL test reset_l=0 driven mid-burst at beat 2 of 8 -> out_valid=0 and sum=0 in the next cycle, and a new request afterwards restarts cleanly.
